// File: rtl/fd_select_iter.sv
// -----------------------------------------------------------------------------
// fd_select_iter
//
// Final quotient selection and sticky generation for the divider.
// The approximate quotient from the iteration unit is truncated to q0
// (N fraction bits in double mode, NS in single mode) and q1 = q0 + ulp.
// The exact remainder A - q1*B is built with a serial radix-2^RB multiplier.
// Its sign and magnitude then select q0 or q1, the sticky bit and the
// precondition-violation flag.
//
// Handshake: an operand transfer happens on a rising edge with
// in_valid && in_ready, and a result transfer on a rising edge with
// out_valid && out_ready. in_ready is high only in IDLE. out_valid is high
// only in DONE, and fd/err are held there until the consumer accepts them.
//
// Ports
//   clk        clock
//   rst        asynchronous active-high reset (aborts any operation)
//   in_valid   operand valid
//   in_ready   block idle, operands accepted this cycle if in_valid
//   a_sig      dividend significand, 1.(N-1) fixed point
//   b_sig      divisor significand, 1.(N-1) fixed point
//   q_appr     approximate quotient, 1 integer bit + N+G fraction bits
//   db         1 = double precision, 0 = single (upper NS bits significant)
//   out_valid  result valid
//   out_ready  consumer accepts result
//   fd         selected quotient and sticky, packed per precision
//   err        precondition violated (q_appr was more than one ulp low)
// -----------------------------------------------------------------------------
module fd_select_iter #(
    parameter int N  = 53,
    parameter int NS = 24,
    parameter int G  = 3,
    parameter int RB = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a_sig,
    input  logic [N-1:0] b_sig,
    input  logic [N+G:0] q_appr,
    input  logic         db,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N+1:0] fd,
    output logic         err
);

    // Multiply cycle counts: enough RB-bit digits to cover q0 (N+1 / NS+1 bits).
    localparam int C_D = (N + 1 + RB - 1) / RB;
    localparam int C_S = (NS + 1 + RB - 1) / RB;
    localparam int SH  = N - NS;
    localparam int PW  = N + RB * C_D;    // partial product width
    localparam int XW  = PW + 2;          // signed remainder width (>= 2N+3)
    localparam int CW  = $clog2(C_D + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  ai_q, ai_d;
    logic [N-1:0]  bi_q, bi_d;
    logic [N:0]    q0_q, q0_d;
    logic          db_q, db_d;
    logic [PW-1:0] acc_q, acc_d;
    logic [PW-1:0] mcand_q, mcand_d;
    logic [N:0]    mplier_q, mplier_d;
    logic [N+1:0]  fd_q, fd_d;
    logic          err_q, err_d;

    // Operand conditioning at capture: single mode clears the bits below the
    // single-precision LSB so they cannot reach the arithmetic.
    logic [N-1:0] lo_mask;
    logic [N:0]   q0_in;

    assign lo_mask = db ? {N{1'b1}} : {{NS{1'b1}}, {SH{1'b0}}};
    // q0 in ulp units: shifting the whole of q_appr drops the truncated bits.
    assign q0_in   = (N+1)'(q_appr >> (db ? G : G + SH));

    // Remainder evaluation. The serial multiplier forms q0*B. The q1 remainder
    // is then (A - q0*B) - ulpB. Because q1 itself is never multiplied, the
    // case q1 = 2.0 needs no extra multiplier digit.
    logic [XW-1:0] a_ext, prod_ext, ulpb, rem0, remi;
    logic [N:0]    q1;
    logic [N:0]    q_sel;
    logic          sticky, viol;

    always_comb begin
        a_ext    = XW'(ai_q) << N;
        prod_ext = XW'(acc_q) << (db_q ? 0 : SH);
        ulpb     = XW'(bi_q) << (db_q ? 0 : SH);
        rem0     = a_ext - prod_ext;          // remi + ulpB
        remi     = rem0 - ulpb;
        q1       = q0_q + (N+1)'(1);
        q_sel    = q1;
        sticky   = 1'b1;
        viol     = 1'b0;
        if (remi[XW-1]) begin
            q_sel  = q0_q;
            sticky = |rem0;
        end else if (remi < ulpb) begin
            sticky = |remi;
        end else begin
            viol   = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ai_d     = ai_q;
        bi_d     = bi_q;
        q0_d     = q0_q;
        db_d     = db_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        fd_d     = fd_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    ai_d     = a_sig & lo_mask;
                    bi_d     = b_sig & lo_mask;
                    q0_d     = q0_in;
                    db_d     = db;
                    acc_d    = '0;
                    mcand_d  = PW'(b_sig & lo_mask);
                    mplier_d = q0_in;
                    cnt_d    = db ? CW'(C_D) : CW'(C_S);
                    state_d  = S_MUL;
                end
            end
            S_MUL: begin
                // LSB-first digit serial: multiplicand shifts up as digits retire.
                acc_d    = acc_q + mcand_q * PW'(mplier_q[RB-1:0]);
                mcand_d  = mcand_q << RB;
                mplier_d = mplier_q >> RB;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                fd_d    = db_q ? {q_sel, sticky} : {q_sel[NS:0], sticky, {SH{1'b0}}};
                err_d   = viol;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ai_q     <= '0;
            bi_q     <= '0;
            q0_q     <= '0;
            db_q     <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            fd_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ai_q     <= ai_d;
            bi_q     <= bi_d;
            q0_q     <= q0_d;
            db_q     <= db_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            fd_q     <= fd_d;
            err_q    <= err_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign fd        = fd_q;
    assign err       = err_q;

endmodule

// File: tb/tb_fd_select_iter.sv
module tb_fd_select_iter;

    localparam int N  = 53;
    localparam int NS = 24;
    localparam int G  = 3;
    localparam int RB = 4;
    localparam int LAT_D = 15;
    localparam int LAT_S = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a_sig;
    logic [N-1:0] b_sig;
    logic [N+G:0] q_appr;
    logic         db;
    logic         out_valid;
    logic         out_ready;
    logic [N+1:0] fd;
    logic         err;

    fd_select_iter #(.N(N), .NS(NS), .G(G), .RB(RB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_sig     (a_sig),
        .b_sig     (b_sig),
        .q_appr    (q_appr),
        .db        (db),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fd        (fd),
        .err       (err)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [N+2:0] exp_q[$];     // {err, fd}
    int           acc_q[$];     // accept cycle numbers
    int           lat_q[$];     // expected latency
    int           checks = 0;
    int           failures = 0;
    int           rdy_mode = 0; // 0: always ready, 1: random, 2: held low

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ---------------- reference model ----------------
    // Exact integer form: remi = Ai*2^N - q1i*Bi, selection from its range.
    function automatic logic [N+2:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [N+G:0] qa, input logic dbm);
        int sh;
        int fb;
        logic [127:0] ai, bi, q0, q1, qs, ulpb, fdv;
        logic signed [127:0] r;
        logic st, e;
        sh   = dbm ? 0 : N - NS;
        fb   = dbm ? N : NS;
        ai   = (128'(a) >> sh) << sh;
        bi   = (128'(b) >> sh) << sh;
        q0   = 128'(qa) >> (N + G - fb);
        q1   = q0 + 128'd1;
        r    = $signed((ai << N) - ((q1 << sh) * bi));
        ulpb = bi << sh;
        if (r < 0) begin
            qs = q0; st = ((r + $signed(ulpb)) != 0); e = 1'b0;
        end else if (r < $signed(ulpb)) begin
            qs = q1; st = (r != 0); e = 1'b0;
        end else begin
            qs = q1; st = 1'b1; e = 1'b1;
        end
        if (dbm) fdv = (qs << 1) | 128'(st);
        else     fdv = (qs << (N - NS + 1)) | (128'(st) << (N - NS));
        return {e, fdv[N+1:0]};
    endfunction

    // ---------------- driver ----------------
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N+G:0] qa,
                        input logic dbm, input logic [N+2:0] expv, input int lat);
        int n;
        n = 0;
        @(negedge clk);
        a_sig = a; b_sig = b; q_appr = qa; db = dbm; in_valid = 1'b1;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            fail_now("accept_timeout");
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(expv);
            acc_q.push_back(cyc + 1);
            lat_q.push_back(lat);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
    endtask

    // ---------------- consumer ready ----------------
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic in_ep;
        logic hs_prev;
        in_ep = 1'b0;
        hs_prev = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                in_ep = 1'b0;
                hs_prev = 1'b0;
            end else begin
                if (hs_prev) begin
                    chk("idle_after_hs", 128'({in_ready, out_valid}), 128'(2'b10));
                    hs_prev = 1'b0;
                end
                if (out_valid) begin
                    if (!in_ep) begin
                        in_ep = 1'b1;
                        if (acc_q.size() == 0) fail_now("unexpected_out_valid");
                        else chk("latency", 128'(cyc - acc_q.pop_front()), 128'(lat_q.pop_front()));
                    end
                    chk("in_ready_busy", 128'(in_ready), 128'(0));
                    if (exp_q.size() == 0) begin
                        fail_now("no_expected_result");
                    end else begin
                        chk("fd", 128'(fd), 128'(exp_q[0][N+1:0]));
                        chk("err", 128'(err), 128'(exp_q[0][N+2]));
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            in_ep = 1'b0;
                            hs_prev = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [N-1:0]  one, onep5, smask, a, b;
        logic [N+G:0]  q_one, q_15m, q_23;
        logic [127:0]  v, t, uq, rr;
        logic [N+2:0]  e1, e2, e3, e4, e5;
        logic [63:0]   r1;
        logic          dbm;
        int            n, k;

        rst = 1'b1; in_valid = 1'b0; a_sig = '0; b_sig = '0; q_appr = '0; db = 1'b0;
        one   = {1'b1, {(N-1){1'b0}}};
        onep5 = {2'b11, {(N-2){1'b0}}};
        smask = {{NS{1'b1}}, {(N-NS){1'b0}}};
        q_one = {1'b1, {(N+G){1'b0}}};
        v = (128'd3 << (N + G - 1)) - 128'd1;          q_15m = v[N+G:0];
        v = (128'd1 << (N + G + 1)) / 128'd3;          q_23  = v[N+G:0];

        v = 128'd1 << 54;                                e1 = v[N+2:0];
        v = 128'd3 << 53;                                e2 = v[N+2:0];
        v = (((128'd1 << 54) / 128'd3) << 1) | 128'd1;   e3 = v[N+2:0];
        v = (((128'd1 << 53) + 128'd1) << 1) | 128'd1 | (128'd1 << (N + 2));
        e4 = v[N+2:0];
        v = (((128'd1 << 25) / 128'd3) << 30) | (128'd1 << 29);
        e5 = v[N+2:0];

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_fd", 128'(fd), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        rst = 1'b0;

        // Directed double cases
        send(one,   one,   q_one, 1'b1, e1, LAT_D);
        send(onep5, one,   q_15m, 1'b1, e2, LAT_D);
        send(one,   onep5, q_23,  1'b1, e3, LAT_D);
        send(onep5, one,   q_one, 1'b1, e4, LAT_D);
        // Single: low operand bits are noise and must not matter
        for (int i = 0; i < 3; i++) begin
            r1 = {$urandom, $urandom};
            a = one | (r1[N-1:0] & ~smask);
            r1 = {$urandom, $urandom};
            b = onep5 | (r1[N-1:0] & ~smask);
            send(a, b, q_23, 1'b0, e5, LAT_S);
        end
        drain();

        // Consumer stall: result must hold, busy input ignored
        rdy_mode = 2;
        send(onep5, one, q_15m, 1'b1, e2, LAT_D);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) fail_now("hold_wait_timeout");
        repeat (10) begin
            @(negedge clk);
            a_sig = onep5; b_sig = one; q_appr = q_one; db = 1'b1; in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rdy_mode = 0;
        drain();
        send(one, onep5, q_23, 1'b1, e3, LAT_D);
        drain();

        // Abort in the middle of the multiply
        send(onep5, one, q_one, 1'b1, e4, LAT_D);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        exp_q.delete(); acc_q.delete(); lat_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", 128'(in_ready), 128'(1));
        chk("abort_out_valid", 128'(out_valid), 128'(0));
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("abort_no_result", 128'(n), 128'(0));
        send(one, onep5, q_23, 1'b1, e3, LAT_D);
        drain();

        // Randomised traffic against the model
        rdy_mode = 1;
        for (int i = 0; i < 60; i++) begin
            dbm = 1'($urandom_range(0, 1));
            r1 = {$urandom, $urandom};
            a = {1'b1, r1[N-2:0]};
            r1 = {$urandom, $urandom};
            b = {1'b1, r1[N-2:0]};
            if ($urandom_range(0, 5) == 0) b = a;
            t  = (128'(dbm ? a : (a & smask)) << (N + G)) / 128'(dbm ? b : (b & smask));
            uq = dbm ? (128'd1 << G) : (128'd1 << (G + N - NS));
            k  = $urandom_range(0, 9);
            rr = 128'({$urandom, $urandom});
            if (k == 0)      t = t - uq * 128'($urandom_range(2, 4));
            else if (k == 1) t = t + uq;
            else             t = t + (rr % uq) - (uq >> 1);
            if (t < (128'd1 << (N + G - 1))) t = 128'd1 << (N + G - 1);
            if (t > ((128'd1 << (N + G + 1)) - 128'd1)) t = (128'd1 << (N + G + 1)) - 128'd1;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(a, b, t[N+G:0], dbm, model(a, b, t[N+G:0], dbm), dbm ? LAT_D : LAT_S);
        end
        drain();
        rdy_mode = 0;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
